// File: rtl/adaptive_cruise_controller.sv
// Adaptive cruise controller: chooses STOPPED/HOLD/ACCEL/DECEL from speed, limit and headway,
// with distance/speed hysteresis, brake override and delayed door unlock after a full stop.
module adaptive_cruise_controller #(
  parameter int SPEED_W      = 8,
  parameter int DIST_W       = 7,
  parameter int MIN_DISTANCE = 50,
  parameter int DIST_HYST    = 5,
  parameter int SPEED_BAND   = 3,
  parameter int STOP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               brake_pedal,
  input  logic [SPEED_W-1:0] speed_limit,
  input  logic [SPEED_W-1:0] car_speed,
  input  logic [DIST_W-1:0]  leading_distance,
  output logic               accelerate_car,
  output logic               decelerate_car,
  output logic               unlock_doors,
  output logic [1:0]         state_o
);

  // A zero-width counter is not legal, so STOP_CYCLES=0 still gets one bit.
  localparam int CNT_W = (STOP_CYCLES > 0) ? $clog2(STOP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   STOP_CNT  = CNT_W'(STOP_CYCLES);
  localparam logic [DIST_W:0]    CLOSE_SET = (DIST_W + 1)'(MIN_DISTANCE);
  localparam logic [DIST_W:0]    CLOSE_CLR = (DIST_W + 1)'(MIN_DISTANCE + DIST_HYST);
  localparam logic [SPEED_W:0]   BAND      = (SPEED_W + 1)'(SPEED_BAND);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    HOLD    = 2'd1,
    ACCEL   = 2'd2,
    DECEL   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             close_reg, close_next;
  logic             accel_reg, decel_reg, unlock_reg;

  logic [DIST_W:0]  dist_ext;
  logic [SPEED_W:0] speed_sum;
  logic [SPEED_W:0] limit_ext;
  logic             speed_zero;

  always_comb begin
    dist_ext   = {1'b0, leading_distance};
    speed_sum  = {1'b0, car_speed} + BAND;
    limit_ext  = {1'b0, speed_limit};
    speed_zero = (car_speed == '0);

    // Headway hysteresis: between the two thresholds the previous verdict stands.
    close_next = close_reg;
    if (dist_ext < CLOSE_SET) begin
      close_next = 1'b1;
    end else if (dist_ext >= CLOSE_CLR) begin
      close_next = 1'b0;
    end

    state_next = HOLD;
    if (speed_zero && (brake_pedal || !enable || close_next || speed_limit == '0)) begin
      state_next = STOPPED;
    end else if (brake_pedal) begin
      state_next = DECEL;
    end else if (!enable) begin
      state_next = HOLD;
    end else if (close_next) begin
      state_next = DECEL;
    end else if (car_speed > speed_limit) begin
      state_next = DECEL;
    end else if (speed_zero || speed_sum < limit_ext) begin
      state_next = ACCEL;
    end

    cnt_next = '0;
    if (state_next == STOPPED && state_reg == STOPPED) begin
      cnt_next = (cnt_reg == STOP_CNT) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= STOPPED;
      cnt_reg    <= '0;
      close_reg  <= 1'b1;
      accel_reg  <= 1'b0;
      decel_reg  <= 1'b0;
      unlock_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      close_reg  <= close_next;
      accel_reg  <= (state_next == ACCEL);
      decel_reg  <= (state_next == DECEL);
      unlock_reg <= (state_next == STOPPED) && (cnt_next == STOP_CNT);
    end
  end

  assign accelerate_car = accel_reg;
  assign decelerate_car = decel_reg;
  assign unlock_doors   = unlock_reg;
  assign state_o        = state_reg;

endmodule

// File: tb/tb_adaptive_cruise_controller.sv
// Directed scoreboard bench for adaptive_cruise_controller (default parameters).
module tb_adaptive_cruise_controller;

  localparam logic [1:0] S_STOP = 2'd0, S_HOLD = 2'd1, S_ACC = 2'd2, S_DEC = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       brake_pedal;
  logic [7:0] speed_limit;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       accelerate_car;
  logic       decelerate_car;
  logic       unlock_doors;
  logic [1:0] state_o;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       acc;
    logic       dec;
    logic       unl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  adaptive_cruise_controller dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .brake_pedal      (brake_pedal),
    .speed_limit      (speed_limit),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .accelerate_car   (accelerate_car),
    .decelerate_car   (decelerate_car),
    .unlock_doors     (unlock_doors),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input string field, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0b expected=%0b", tag, field, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, then pop and compare.
  task automatic step(input string tag, input logic r, input logic en, input logic br,
                      input logic [7:0] lim, input logic [7:0] spd, input logic [6:0] dst,
                      input logic [1:0] st, input logic unl);
    exp_t e;
    exp_t got;
    rst = r; enable = en; brake_pedal = br;
    speed_limit = lim; car_speed = spd; leading_distance = dst;
    e.tag = tag; e.st = st; e.unl = unl;
    e.acc = (st == S_ACC);
    e.dec = (st == S_DEC);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    checks++;
    assert (state_o === got.st) else begin
      errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", got.tag, state_o, got.st);
    end
    check_bit(got.tag, "accel", accelerate_car, got.acc);
    check_bit(got.tag, "decel", decelerate_car, got.dec);
    check_bit(got.tag, "unlock", unlock_doors, got.unl);
    $display("step %-14s rst=%0b en=%0b brk=%0b lim=%0d spd=%0d dist=%0d -> state=%0d acc=%0b dec=%0b unl=%0b",
             got.tag, r, en, br, lim, spd, dst, state_o, accelerate_car, decelerate_car, unlock_doors);
  endtask

  initial begin
    // Reset held for three edges
    for (int i = 0; i < 3; i++) step("reset", 0, 0, 0, 8'd0, 8'd0, 7'd0, S_STOP, 0);

    step("release", 1, 1, 0, 8'd60, 8'd40, 7'd80, S_ACC, 0);

    // Distance hysteresis
    step("dist52", 1, 1, 0, 8'd60, 8'd40, 7'd52, S_ACC, 0);
    step("dist49", 1, 1, 0, 8'd60, 8'd40, 7'd49, S_DEC, 0);
    step("dist53", 1, 1, 0, 8'd60, 8'd40, 7'd53, S_DEC, 0);
    step("dist54", 1, 1, 0, 8'd60, 8'd40, 7'd54, S_DEC, 0);
    step("dist55", 1, 1, 0, 8'd60, 8'd40, 7'd55, S_ACC, 0);

    // Speed band
    step("spd58", 1, 1, 0, 8'd60, 8'd58, 7'd80, S_HOLD, 0);
    step("spd70", 1, 1, 0, 8'd60, 8'd70, 7'd80, S_DEC, 0);
    step("spd56", 1, 1, 0, 8'd60, 8'd56, 7'd80, S_ACC, 0);
    step("spd57", 1, 1, 0, 8'd60, 8'd57, 7'd80, S_HOLD, 0);
    step("spd60", 1, 1, 0, 8'd60, 8'd60, 7'd80, S_HOLD, 0);

    // Speed-rule edge cases
    step("lim254spd255", 1, 1, 0, 8'd254, 8'd255, 7'd80, S_DEC, 0);
    step("lim255spd254", 1, 1, 0, 8'd255, 8'd254, 7'd80, S_HOLD, 0);
    step("lim2spd0", 1, 1, 0, 8'd2, 8'd0, 7'd80, S_ACC, 0);
    step("lim2spd1", 1, 1, 0, 8'd2, 8'd1, 7'd80, S_HOLD, 0);
    step("lim0spd0", 1, 1, 0, 8'd0, 8'd0, 7'd80, S_STOP, 0);
    step("lim2spd0b", 1, 1, 0, 8'd2, 8'd0, 7'd80, S_ACC, 0);

    // Stop and unlock after STOP_CYCLES edges
    step("stop_k", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("stop_k1", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("stop_k2", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("stop_k3", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("stop_k4", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 1);
    step("stop_k5", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 1);
    step("brake_spd5", 1, 1, 1, 8'd60, 8'd5, 7'd80, S_DEC, 0);

    // Enable override
    step("en_drop", 1, 0, 0, 8'd60, 8'd40, 7'd80, S_HOLD, 0);
    step("en_back", 1, 1, 0, 8'd60, 8'd40, 7'd80, S_ACC, 0);

    // Stop, unlock, then reset mid-stop and re-unlock
    step("stop2_k", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    for (int i = 0; i < 3; i++) step("stop2_wait", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("stop2_unl", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 1);
    step("rst_pulse", 0, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    for (int i = 0; i < 3; i++) step("post_rst_wait", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 0);
    step("post_rst_unl", 1, 1, 1, 8'd60, 8'd0, 7'd80, S_STOP, 1);

    // close_flag resets to 1: inside the hysteresis band the car must still back off
    step("rst2", 0, 1, 0, 8'd60, 8'd40, 7'd52, S_STOP, 0);
    step("rst2_dist52", 1, 1, 0, 8'd60, 8'd40, 7'd52, S_DEC, 0);
    step("rst2_dist55", 1, 1, 0, 8'd60, 8'd40, 7'd55, S_ACC, 0);
    step("close_spd0", 1, 1, 0, 8'd60, 8'd0, 7'd10, S_STOP, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
